// File: rtl/i2c_bus_capture.sv
// I2C bus analyser: synchronises and deglitches SCL/SDA, decodes bus events,
// queues tagged entries in a capture FIFO and keeps bus statistics counters.
module i2c_bus_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int DEPTH_LOG2  = 8,
  parameter int CNT_W       = 16
) (
  input  logic                  i_clk,
  input  logic                  i_key,
  input  logic                  i_scl,
  input  logic                  i_sda,
  input  logic                  i_cap_en,
  input  logic                  i_clr,
  input  logic                  i_rd_en,
  output logic [10:0]           o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_overflow,
  output logic [CNT_W-1:0]      o_drop_cnt,
  output logic [CNT_W-1:0]      o_byte_cnt,
  output logic [CNT_W-1:0]      o_nack_cnt,
  output logic [CNT_W-1:0]      o_frame_cnt,
  output logic [CNT_W-1:0]      o_trunc_cnt
);

  localparam int FCW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  localparam logic [1:0] TYPE_BYTE    = 2'b00;
  localparam logic [1:0] TYPE_START   = 2'b01;
  localparam logic [1:0] TYPE_RESTART = 2'b10;
  localparam logic [1:0] TYPE_STOP    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclSync;
  logic [SYNC_STAGES-1:0] r_sdaSync;
  logic [1:0]             w_syncLvl;
  logic [1:0]             r_filt;
  logic [1:0]             r_filtPrev;
  logic [1:0][FCW-1:0]    r_fCnt;

  logic w_sclChg;
  logic w_sclRise;
  logic w_start;
  logic w_stop;

  state_t      r_state;
  state_t      w_stateNext;
  logic [2:0]  r_bitIdx;
  logic [2:0]  w_bitIdxNext;
  logic [7:0]  r_shift;
  logic [7:0]  w_shiftNext;
  logic        w_midByte;
  logic        w_push;
  logic [10:0] w_entry;
  logic        w_frameInc;
  logic        w_byteInc;
  logic        w_nackInc;
  logic        w_truncInc;

  logic [10:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [LW-1:0]         r_level;
  logic [10:0]           r_rdData;
  logic                  r_rdValid;
  logic                  r_overflow;
  logic [CNT_W-1:0]      r_dropCnt;
  logic [CNT_W-1:0]      r_byteCnt;
  logic [CNT_W-1:0]      r_nackCnt;
  logic [CNT_W-1:0]      r_frameCnt;
  logic [CNT_W-1:0]      r_truncCnt;

  logic w_empty;
  logic w_full;
  logic w_pushReq;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  // Synchronisers idle high so a released bus never looks like an event.
  always_ff @(posedge i_clk or negedge i_key) begin
    if (!i_key) begin
      r_sclSync <= '1;
      r_sdaSync <= '1;
    end else begin
      r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], i_scl};
      r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], i_sda};
    end
  end

  assign w_syncLvl = {r_sdaSync[SYNC_STAGES-1], r_sclSync[SYNC_STAGES-1]};

  // Index 0 is SCL, index 1 is SDA; a level is accepted after FILTER_LEN equal samples.
  always_ff @(posedge i_clk or negedge i_key) begin
    if (!i_key) begin
      r_filt     <= 2'b11;
      r_filtPrev <= 2'b11;
      r_fCnt     <= '0;
    end else begin
      r_filtPrev <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (w_syncLvl[i] == r_filt[i]) begin
          r_fCnt[i] <= '0;
        end else if (r_fCnt[i] == FCW'(FILTER_LEN - 1)) begin
          r_filt[i] <= w_syncLvl[i];
          r_fCnt[i] <= '0;
        end else begin
          r_fCnt[i] <= r_fCnt[i] + FCW'(1);
        end
      end
    end
  end

  // An SDA change coinciding with an SCL change is treated as a clock edge only.
  assign w_sclChg  = r_filt[0] ^ r_filtPrev[0];
  assign w_sclRise = r_filt[0] & ~r_filtPrev[0];
  assign w_start   = r_filtPrev[1] & ~r_filt[1] & r_filt[0] & ~w_sclChg;
  assign w_stop    = ~r_filtPrev[1] & r_filt[1] & r_filt[0] & ~w_sclChg;

  always_ff @(posedge i_clk or negedge i_key) begin
    if (!i_key) begin
      r_state  <= ST_IDLE;
      r_bitIdx <= 3'd7;
      r_shift  <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_bitIdx <= w_bitIdxNext;
      r_shift  <= w_shiftNext;
    end
  end

  assign w_midByte = (r_state == ST_ACK) || ((r_state == ST_DATA) && (r_bitIdx != 3'd7));

  always_comb begin
    w_stateNext  = r_state;
    w_bitIdxNext = r_bitIdx;
    w_shiftNext  = r_shift;
    w_push       = 1'b0;
    w_entry      = '0;
    w_frameInc   = 1'b0;
    w_byteInc    = 1'b0;
    w_nackInc    = 1'b0;
    w_truncInc   = 1'b0;
    if (w_start) begin
      w_push       = 1'b1;
      w_entry      = {(r_state == ST_IDLE) ? TYPE_START : TYPE_RESTART, 9'd0};
      w_frameInc   = 1'b1;
      w_truncInc   = w_midByte;
      w_stateNext  = ST_DATA;
      w_bitIdxNext = 3'd7;
    end else if (w_stop) begin
      w_push       = 1'b1;
      w_entry      = {TYPE_STOP, 9'd0};
      w_truncInc   = w_midByte;
      w_stateNext  = ST_IDLE;
      w_bitIdxNext = 3'd7;
    end else if (w_sclRise) begin
      case (r_state)
        ST_DATA: begin
          w_shiftNext[r_bitIdx] = r_filt[1];
          if (r_bitIdx == 3'd0) begin
            w_stateNext = ST_ACK;
          end else begin
            w_bitIdxNext = r_bitIdx - 3'd1;
          end
        end
        ST_ACK: begin
          w_push       = 1'b1;
          w_entry      = {TYPE_BYTE, r_filt[1], r_shift};
          w_byteInc    = 1'b1;
          w_nackInc    = r_filt[1];
          w_stateNext  = ST_DATA;
          w_bitIdxNext = 3'd7;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_key) begin
    if (!i_key) begin
      r_byteCnt  <= '0;
      r_nackCnt  <= '0;
      r_frameCnt <= '0;
      r_truncCnt <= '0;
    end else if (i_clr) begin
      r_byteCnt  <= '0;
      r_nackCnt  <= '0;
      r_frameCnt <= '0;
      r_truncCnt <= '0;
    end else begin
      if (w_byteInc)  r_byteCnt  <= r_byteCnt + CNT_W'(1);
      if (w_nackInc)  r_nackCnt  <= r_nackCnt + CNT_W'(1);
      if (w_frameInc) r_frameCnt <= r_frameCnt + CNT_W'(1);
      if (w_truncInc) r_truncCnt <= r_truncCnt + CNT_W'(1);
    end
  end

  // A pop frees the slot in the same cycle, so a full FIFO accepts push+pop together.
  assign w_empty   = (r_level == '0);
  assign w_full    = r_level[DEPTH_LOG2];
  assign w_pushReq = w_push & i_cap_en;
  assign w_pop     = i_rd_en & ~w_empty;
  assign w_wr      = w_pushReq & (~w_full | w_pop);
  assign w_drop    = w_pushReq & w_full & ~w_pop;

  always_ff @(posedge i_clk) begin
    if (w_wr && !i_clr) begin
      r_mem[r_wrPtr] <= w_entry;
    end
  end

  always_ff @(posedge i_clk or negedge i_key) begin
    if (!i_key) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_level    <= '0;
      r_rdData   <= '0;
      r_rdValid  <= 1'b0;
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else if (i_clr) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_level    <= '0;
      r_rdValid  <= 1'b0;
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else begin
      r_rdValid <= w_pop;
      if (w_pop) begin
        r_rdData <= r_mem[r_rdPtr];
        r_rdPtr  <= r_rdPtr + DEPTH_LOG2'(1);
      end
      if (w_wr) begin
        r_wrPtr <= r_wrPtr + DEPTH_LOG2'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: ;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropCnt != '1) begin
          r_dropCnt <= r_dropCnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_rd_data   = r_rdData;
  assign o_rd_valid  = r_rdValid;
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_level     = r_level;
  assign o_overflow  = r_overflow;
  assign o_drop_cnt  = r_dropCnt;
  assign o_byte_cnt  = r_byteCnt;
  assign o_nack_cnt  = r_nackCnt;
  assign o_frame_cnt = r_frameCnt;
  assign o_trunc_cnt = r_truncCnt;

endmodule

// File: doc/i2c_bus_capture.md
Name: i2c_bus_capture

Overview:
- Second-generation I2C bus analyser; replaces per-edge-clocked SCL/SDA counting with fully synchronous capture on clk.
- Synchronises and deglitches SCL/SDA, decodes START/RESTART/STOP/data-byte/ACK events and pushes tagged entries into a parametrised capture FIFO.
- Also maintains bus statistics counters. The FIFO is drained by the board readout logic (7-seg/memory viewer).

Parameters:
- SYNC_STAGES, 2, synchroniser flops per input (>=2)
- FILTER_LEN, 3, clocks a synchronised level must be stable before the filtered level changes (>=1)
- DEPTH_LOG2, 8, FIFO depth = 2**DEPTH_LOG2 entries
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  system clock
- key  in  1  asynchronous active-low reset
- scl  in  1  raw bus SCL (asynchronous)
- sda  in  1  raw bus SDA (asynchronous)
- cap_en  in  1  1 = push decoded entries to FIFO; decoding runs regardless
- clr  in  1  synchronous clear of FIFO, drop flag and all counters
- rd_en  in  1  pop request
- rd_data  out  11  popped entry: [10:9] type (00 byte, 01 START, 10 RESTART, 11 STOP), [8] ack bit, [7:0] data
- rd_valid  out  1  rd_data valid, one-cycle pulse
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- level  out  DEPTH_LOG2+1  FIFO occupancy
- overflow  out  1  sticky; set when an entry was dropped
- drop_cnt  out  CNT_W  dropped entries, saturating
- byte_cnt  out  CNT_W  completed bytes, wraps
- nack_cnt  out  CNT_W  bytes with ack bit 1, wraps
- frame_cnt  out  CNT_W  START+RESTART count, wraps
- trunc_cnt  out  CNT_W  bytes aborted by START/STOP mid-byte, wraps

Behaviour:
- Reset (key=0, async): all outputs 0 except empty=1; FSM=IDLE; filtered scl/sda=1; sync flops=1.
- Input path: SYNC_STAGES flops, then stability filter. The filtered level follows after FILTER_LEN consecutive equal samples. Edge detection uses the filtered levels of the previous vs current cycle. Input-to-event latency = SYNC_STAGES+FILTER_LEN+1 clocks.
- Conditions:
  - START = sda_f falling while scl_f=1.
  - STOP = sda_f rising while scl_f=1.
  - Bit sample = scl_f rising, with sda_f taken in the same cycle.
  - If scl_f and sda_f change in the same cycle, the cycle is treated as a scl edge only; no START/STOP is decoded.
- FSM states:
  - IDLE: scl edges ignored. START -> push START, frame_cnt++, go DATA, bit index=7.
  - DATA: each scl rise stores sda_f at the bit index (MSB first) and decrements the index. After bit 0 -> ACK.
  - ACK: next scl rise samples the ack bit; push byte entry; byte_cnt++; nack_cnt++ if ack=1; -> DATA, index=7.
  - Any state other than IDLE: START -> push RESTART, frame_cnt++, DATA index 7. STOP -> push STOP, -> IDLE.
  - Mid-byte abort: START/STOP in DATA with index!=7, or in ACK, increments trunc_cnt. The partial byte is discarded.
  - STOP in IDLE: push STOP, stay IDLE.
- FIFO: synchronous, registered read.
  - Pop: rd_en && !empty pops; rd_data/rd_valid appear the next cycle. rd_en when empty is ignored, with rd_valid=0. rd_data holds its last value when rd_valid=0.
  - Push: push && !full writes. Push && full && !pop drops the entry: overflow=1, drop_cnt++ (saturating at all-ones).
  - Simultaneous push and pop when full: both succeed, level unchanged.
  - cap_en=0 suppresses the push only; counters still update.
  - Pointers are DEPTH_LOG2 bits wide, wrap modulo depth; level = writes-reads.
- clr: next cycle FIFO empty, level=0, overflow=0, all counters 0. The FSM and filters are not affected. clr takes priority over a same-cycle push/pop.
- Mid-operation key assertion returns everything to the reset state immediately. The first event after release requires a fresh START.

Test Plan:
- Reset, then write 0xA2 with ACK and a 0x5C byte with NACK, then STOP -> FIFO holds {01,0,00},{00,0,A2},{00,1,5C},{11,0,00}; byte_cnt=2, nack_cnt=1, frame_cnt=1.
- START, 0x3C, then repeated START, 0x91 ACK, STOP -> entries START, 3C, RESTART, 91, STOP; frame_cnt=2.
- START, 4 bits, then STOP -> entries START, STOP; trunc_cnt=1; byte_cnt=0.
- 1-clock SDA glitch while SCL high, FILTER_LEN=3 -> no entry, all counters 0.
- DEPTH_LOG2=2: cap 6 entries with no reads -> full=1, level=4, overflow=1, drop_cnt=2. Pop 4 -> values in order, rd_valid one cycle after each rd_en, empty=1 after the last pop.
- Assert clr with level=3 and counters non-zero -> next cycle level=0, empty=1, counters 0; a following byte decodes normally.
